// File: rtl/alu_pkg.sv
// alu_pkg: shared types and the status-flag rule for the pipelined ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_NOT = 3'b011,
    OP_MUL = 3'b100,
    OP_LSL = 3'b101,
    OP_ASR = 3'b110,
    OP_MOV = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  typedef struct packed {
    logic z;
    logic n;
    logic v;
  } alu_flags_t;

  // Flags depend only on a handful of bits of result and operands, so the
  // caller passes those bits; this keeps the function independent of WIDTH.
  // a_msb2 is the bit just below the sign of A (needed for the LSL overflow).
  function automatic alu_flags_t alu_flags(
    input logic    res_zero,
    input logic    res_msb,
    input logic    a_msb,
    input logic    a_msb2,
    input logic    b_msb,
    input alu_op_t op,
    input logic    prod_ovf
  );
    alu_flags_t f;
    f.z = res_zero;
    f.n = res_msb;
    case (op)
      OP_ADD:  f.v = (a_msb == b_msb) && (res_msb != a_msb);
      OP_SUB:  f.v = (a_msb != b_msb) && (res_msb != a_msb);
      OP_MUL:  f.v = prod_ovf;
      OP_LSL:  f.v = a_msb ^ a_msb2;
      default: f.v = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result handshake bundle between producer, ALU and consumer.
interface alu_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] ain;
  logic [WIDTH-1:0] bin;
  logic [2:0]       aluop;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             Z;
  logic             N;
  logic             V;
  logic             busy;

  // Master: the stage issuing operations and consuming results.
  modport master (
    output in_valid, ain, bin, aluop, out_ready,
    input  in_ready, out_valid, out, Z, N, V, busy
  );

  // Slave: the ALU itself.
  modport slave (
    input  in_valid, ain, bin, aluop, out_ready,
    output in_ready, out_valid, out, Z, N, V, busy
  );
endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: radix-2 shift-add signed multiplier, one partial product per
// clock. Iteration 0 happens on the start edge, so done pulses in the cycle
// after the WIDTH-th partial product has been accumulated.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic             ovf
);
  localparam int CW = ($clog2(WIDTH) > 4) ? $clog2(WIDTH) : 4;

  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [CW-1:0]      cnt_reg;
  logic               running_reg;
  logic               done_reg;

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] term;
  logic               last;

  assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
  assign term  = mplier_reg[0] ? mcand_reg : '0;
  // B's sign bit carries weight -2^(WIDTH-1), so the final partial product is subtracted.
  assign last  = (cnt_reg == CW'(WIDTH - 1));

  // Load operands with the first partial product, then accumulate one bit per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      cnt_reg     <= '0;
      running_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        acc_reg     <= b[0] ? a_ext : '0;
        mcand_reg   <= a_ext << 1;
        mplier_reg  <= b >> 1;
        cnt_reg     <= CW'(1);
        running_reg <= 1'b1;
      end else if (running_reg) begin
        acc_reg    <= last ? (acc_reg - term) : (acc_reg + term);
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        cnt_reg    <= cnt_reg + CW'(1);
        if (last) begin
          running_reg <= 1'b0;
          done_reg    <= 1'b1;
        end
      end
    end
  end

  assign done    = done_reg;
  assign prod_lo = acc_reg[WIDTH-1:0];
  assign ovf     = (acc_reg[2*WIDTH-1:WIDTH] != {WIDTH{acc_reg[WIDTH-1]}});

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with registered result/flags and an optional
// iterative multiplier that stalls the input side while it runs.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input logic       clk,
  input logic       reset_n,
  alu_pipe_if.slave bus
);
  alu_state_t       state_reg;
  logic [WIDTH-1:0] out_reg;
  alu_flags_t       flags_reg;

  alu_op_t          op;
  logic             accept;
  logic             start_mul;
  logic [WIDTH-1:0] res_comb;
  alu_flags_t       flags_comb;
  alu_flags_t       flags_mul;

  logic             mul_done;
  logic [WIDTH-1:0] mul_lo;
  logic             mul_ovf;

  assign op        = alu_op_t'(bus.aluop);
  assign bus.in_ready = (state_reg == IDLE) || ((state_reg == DONE) && bus.out_ready);
  assign accept    = bus.in_valid && bus.in_ready;
  assign start_mul = accept && (op == OP_MUL) && MUL_EN;

  // Single-cycle result; MUL lands here only when no multiplier is built.
  always_comb begin
    res_comb = '0;
    case (op)
      OP_ADD:  res_comb = bus.ain + bus.bin;
      OP_SUB:  res_comb = bus.ain - bus.bin;
      OP_AND:  res_comb = bus.ain & bus.bin;
      OP_NOT:  res_comb = ~bus.bin;
      OP_MUL:  res_comb = '0;
      OP_LSL:  res_comb = bus.ain << 1;
      OP_ASR:  res_comb = $signed(bus.ain) >>> 1;
      OP_MOV:  res_comb = bus.bin;
      default: res_comb = '0;
    endcase
  end

  // prod_ovf tied high: on the single-cycle path MUL can only mean "not built".
  assign flags_comb = alu_flags(res_comb == '0, res_comb[WIDTH-1], bus.ain[WIDTH-1],
                                bus.ain[WIDTH-2], bus.bin[WIDTH-1], op, 1'b1);
  assign flags_mul  = alu_flags(mul_lo == '0, mul_lo[WIDTH-1], 1'b0, 1'b0, 1'b0,
                                OP_MUL, mul_ovf);

  generate
    if (MUL_EN) begin : gen_mul
      alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start_mul),
        .a       (bus.ain),
        .b       (bus.bin),
        .done    (mul_done),
        .prod_lo (mul_lo),
        .ovf     (mul_ovf)
      );
    end else begin : gen_no_mul
      assign mul_done = 1'b0;
      assign mul_lo   = '0;
      assign mul_ovf  = 1'b0;
    end
  endgenerate

  // Control FSM plus result/flag registers; results only change on entry to DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      out_reg   <= '0;
      flags_reg <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            if (start_mul) begin
              state_reg <= MUL;
            end else begin
              state_reg <= DONE;
              out_reg   <= res_comb;
              flags_reg <= flags_comb;
            end
          end else if ((state_reg == DONE) && bus.out_ready) begin
            state_reg <= IDLE;
          end
        end
        MUL: begin
          if (mul_done) begin
            state_reg <= DONE;
            out_reg   <= mul_lo;
            flags_reg <= flags_mul;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = (state_reg == DONE);
  assign bus.busy      = (state_reg == MUL);
  assign bus.out       = out_reg;
  assign bus.Z         = flags_reg.z;
  assign bus.N         = flags_reg.n;
  assign bus.V         = flags_reg.v;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: randomized + directed self-checking bench for alu_pipe
// (MUL_EN=1 main instance, MUL_EN=0 secondary instance).
module tb_alu_pipe;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(W)) bus  ();
  alu_pipe_if #(.WIDTH(W)) bus0 ();

  alu_pipe #(.WIDTH(W), .MUL_EN(1'b1)) dut  (.clk(clk), .reset_n(reset_n), .bus(bus));
  alu_pipe #(.WIDTH(W), .MUL_EN(1'b0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: signed integer arithmetic, overflow = true value outside W-bit range.
  function automatic void ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                  input bit mul_en, output logic [15:0] r,
                                  output logic z, output logic n, output logic v);
    int sa, sb, full;
    bit ranged;
    sa = int'($signed(a));
    sb = int'($signed(b));
    full = 0;
    ranged = 1'b0;
    case (op)
      3'd0: begin full = sa + sb; ranged = 1'b1; end
      3'd1: begin full = sa - sb; ranged = 1'b1; end
      3'd2: full = int'($signed(a & b));
      3'd3: full = int'($signed(~b));
      3'd4: begin full = sa * sb; ranged = 1'b1; end
      3'd5: begin full = sa * 2;  ranged = 1'b1; end
      3'd6: full = sa >>> 1;
      default: full = sb;
    endcase
    r = full[15:0];
    v = ranged && ((full < -32768) || (full > 32767));
    if (op == 3'd4 && !mul_en) begin
      r = 16'h0000;
      v = 1'b1;
    end
    z = (r == 16'h0000);
    n = r[15];
  endfunction

  // One transaction on the main DUT; starts and ends at posedge+1 with the DUT idle.
  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int hold, input string tag);
    logic [15:0] er;
    logic ez, en, ev;
    int lat, exp_lat;
    ref_alu(op, a, b, 1'b1, er, ez, en, ev);
    exp_lat = (op == 3'd4) ? W + 1 : 1;
    check({tag, "/in_ready"}, bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.aluop     = op;
    bus.ain       = a;
    bus.bin       = b;
    bus.out_ready = (hold == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.ain      = 16'($urandom);
    bus.bin      = 16'($urandom);
    bus.aluop    = 3'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 64) begin
      if (op == 3'd4) begin
        check({tag, "/busy"}, bus.busy, 1);
        check({tag, "/stall"}, bus.in_ready, 0);
      end
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/latency"}, lat, exp_lat);
    check({tag, "/out"}, bus.out, er);
    check({tag, "/ZNV"}, {bus.Z, bus.N, bus.V}, {ez, en, ev});
    for (int i = 0; i < hold; i++) begin
      check({tag, "/hold_rdy"}, bus.in_ready, 0);
      @(posedge clk); #1;
      check({tag, "/hold_out"}, {bus.out_valid, bus.out}, {1'b1, er});
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "/drain"}, bus.out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] er, corner_a, corner_b;
    logic ez, en, ev;
    logic [2:0] sop [6];
    logic [15:0] sa [6];
    logic [15:0] sb [6];
    int seen;
    logic [15:0] corners [6];

    corners[0] = 16'h0000; corners[1] = 16'h0001; corners[2] = 16'h7FFF;
    corners[3] = 16'h8000; corners[4] = 16'hFFFF; corners[5] = 16'h4000;

    bus.in_valid = 1'b0;  bus.ain = '0;  bus.bin = '0;  bus.aluop = '0;  bus.out_ready = 1'b1;
    bus0.in_valid = 1'b0; bus0.ain = '0; bus0.bin = '0; bus0.aluop = '0; bus0.out_ready = 1'b1;
    reset_n = 1'b0;
    #2;
    check("reset/outs", {bus.out_valid, bus.busy, bus.out, bus.Z, bus.N, bus.V}, 0);
    @(posedge clk); @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("reset/in_ready", bus.in_ready, 1);

    // Directed corner cases.
    run_op(3'd0, 16'h7FFF, 16'h0001, 0, "add_ovf");
    run_op(3'd0, 16'hFFFF, 16'h0001, 0, "add_zero");
    run_op(3'd1, 16'h0005, 16'h0005, 0, "sub_zero");
    run_op(3'd1, 16'h8000, 16'h0001, 0, "sub_ovf");
    run_op(3'd4, 16'hFFFD, 16'h0007, 0, "mul_neg");
    run_op(3'd4, 16'h0100, 16'h0100, 0, "mul_ovf");
    run_op(3'd3, 16'h1234, 16'h00FF, 0, "not");
    run_op(3'd5, 16'h4000, 16'h0000, 0, "lsl");
    run_op(3'd6, 16'h8001, 16'h0000, 0, "asr");
    run_op(3'd7, 16'h5555, 16'h0000, 0, "mov_zero");

    // Backpressure, then same-cycle drain + accept.
    bus.in_valid = 1'b1; bus.aluop = 3'd0; bus.ain = 16'd1; bus.bin = 16'd2; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp/first", {bus.out_valid, bus.out}, {1'b1, 16'h0003});
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp/stable", {bus.out_valid, bus.in_ready, bus.out}, {1'b1, 1'b0, 16'h0003});
    end
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.aluop = 3'd2; bus.ain = 16'h0F0F; bus.bin = 16'h00FF;
    #1;
    check("bp/rdy_drain", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp/and", {bus.out_valid, bus.out}, {1'b1, 16'h000F});
    @(posedge clk); #1;
    check("bp/drain", bus.out_valid, 0);

    // Back-to-back stream of single-cycle ops: one result per cycle.
    for (int k = 0; k < 6; k++) begin
      sop[k] = 3'($urandom_range(0, 6));
      if (sop[k] >= 3'd4) sop[k] = sop[k] + 3'd1;
      sa[k] = 16'($urandom);
      sb[k] = 16'($urandom);
    end
    bus.in_valid = 1'b1; bus.aluop = sop[0]; bus.ain = sa[0]; bus.bin = sb[0];
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      ref_alu(sop[k-1], sa[k-1], sb[k-1], 1'b1, er, ez, en, ev);
      check("stream/out", {bus.out_valid, bus.out, bus.Z, bus.N, bus.V}, {1'b1, er, ez, en, ev});
      if (k < 6) begin
        bus.aluop = sop[k]; bus.ain = sa[k]; bus.bin = sb[k];
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    check("stream/drain", bus.out_valid, 0);

    // Reset during the 8th multiply cycle.
    run_op(3'd7, 16'h0000, 16'hA5A5, 0, "pre_rst");
    bus.in_valid = 1'b1; bus.aluop = 3'd4; bus.ain = 16'h0123; bus.bin = 16'h0045;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("rst/mid_busy", bus.busy, 1);
    reset_n = 1'b0;
    #1;
    check("rst/outs", {bus.out_valid, bus.busy, bus.out, bus.Z, bus.N, bus.V}, 0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid || bus.busy) seen++;
    end
    check("rst/no_stale", seen, 0);
    run_op(3'd0, 16'd2, 16'd3, 0, "post_rst_add");

    // Randomized traffic with corner-biased operands and random backpressure.
    for (int t = 0; t < 150; t++) begin
      corner_a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
      corner_b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
      run_op(3'($urandom_range(0, 7)), corner_a, corner_b, $urandom_range(0, 3), "rand");
    end

    // MUL_EN=0 instance: MUL is single-cycle, out=0, V=1.
    bus0.in_valid = 1'b1; bus0.aluop = 3'd4; bus0.ain = 16'hFFFD; bus0.bin = 16'h0007;
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    check("nomul/mul", {bus0.out_valid, bus0.busy, bus0.out, bus0.Z, bus0.N, bus0.V},
          {1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1});
    @(posedge clk); #1;
    check("nomul/drain", bus0.out_valid, 0);
    for (int t = 0; t < 20; t++) begin
      sop[0] = 3'($urandom_range(0, 7));
      sa[0]  = 16'($urandom);
      sb[0]  = 16'($urandom);
      bus0.in_valid = 1'b1; bus0.aluop = sop[0]; bus0.ain = sa[0]; bus0.bin = sb[0];
      @(posedge clk); #1;
      bus0.in_valid = 1'b0;
      ref_alu(sop[0], sa[0], sb[0], 1'b0, er, ez, en, ev);
      check("nomul/rand", {bus0.out_valid, bus0.out, bus0.Z, bus0.N, bus0.V}, {1'b1, er, ez, en, ev});
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the datapath ALU, sitting between the register-file read stage and the writeback mux.
- Registers results and status flags (Z, N, V) for every op; V and N are defined for all ops, not only subtract.
- Adds shifts and an iterative signed multiply with valid/ready flow control, so the controller FSM can stall on it.

Parameters:
- WIDTH, 16, operand/result width in bits; legal range >= 4.
- MUL_EN, 1, 1 = iterative multiplier built; 0 = op MUL completes in 1 cycle with out=0, V=1.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block can accept; transfer when in_valid & in_ready at rising clk.
- ain  in  WIDTH  signed operand A.
- bin  in  WIDTH  signed operand B.
- aluop  in  3  operation select (see Behaviour).
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts; transfer when out_valid & out_ready.
- out  out  WIDTH  registered result.
- Z  out  1  registered zero flag.
- N  out  1  registered negative flag.
- V  out  1  registered overflow flag.
- busy  out  1  high while a multiply iterates.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; out, Z, N, V, out_valid, busy = 0.
  - Any in-flight multiply is discarded; no result is produced for it.
- Ops:
  - 000 ADD: A+B.
  - 001 SUB: A-B.
  - 010 AND: A&B.
  - 011 NOT: ~B.
  - 100 MUL: low WIDTH bits of signed A*B.
  - 101 LSL: A<<1.
  - 110 ASR: A>>>1, sign preserved.
  - 111 MOV: pass B.
- Flags, computed on the final result for every op:
  - Z = (out==0); N = out[WIDTH-1].
  - V for ADD: operands share a sign and the result sign differs.
  - V for SUB: A and B signs differ and the result sign differs from A.
  - V for MUL: full 2*WIDTH signed product != sign-extension of its low WIDTH bits.
  - V for LSL: A[WIDTH-1] ^ A[WIDTH-2].
  - V for AND/NOT/ASR/MOV: 0.
- Arithmetic wraps modulo 2^WIDTH; no saturation.
- FSM states and transitions:
  - IDLE: in_ready=1. Accept of a non-MUL op -> DONE. Accept of MUL (MUL_EN=1) -> MUL.
  - MUL: busy=1, in_ready=0, 4-bit-or-wider iteration counter runs WIDTH cycles, then -> DONE.
  - DONE: out_valid=1; out and flags held stable until out_ready.
  - DONE with out_ready and no accept -> IDLE.
- Back-to-back: in_ready = IDLE | (DONE & out_ready). A same-cycle drain+accept goes directly to DONE (non-MUL) or MUL, giving one result per cycle for single-cycle ops.
- Latency from accept edge to out_valid high:
  - Single-cycle ops: 1 cycle.
  - MUL with MUL_EN=1: exactly WIDTH+1 cycles.
  - MUL with MUL_EN=0: 1 cycle.
- Operands and op are captured at accept; ain/bin/aluop may change freely afterwards.
- out_valid never drops without an out_ready handshake, except on reset.
- aluop containing X/Z at accept: out and flags are don't-care, but the FSM must still return to DONE with normal latency.
- No latches: every output is driven from registers on every path.

Decomposition:
- Package alu_pkg:
  - alu_op_t enum (3 bits, encodings above).
  - alu_state_t enum {IDLE, MUL, DONE}.
  - Flag-computation function (result, a, b, op, product-overflow) -> {Z,N,V}.
- Sub-module alu_mul_iter:
  - Ports: clk, reset_n, start, a, b -> done, prod_lo, ovf.
  - Radix-2 shift-add, WIDTH iterations; internal algorithm is free provided latency matches.
  - Instantiated only under MUL_EN=1 (generate).
- Top level holds the FSM, the single-cycle combinational ops and the output registers.

Test Plan:
- ADD 0x7FFF+0x0001 -> 1 cycle later out_valid=1, out=0x8000, N=1, V=1, Z=0. ADD 0xFFFF+0x0001 -> 0x0000, Z=1, V=0.
- SUB 0x0005-0x0005 -> 0x0000, Z=1, N=0, V=0. SUB 0x8000-0x0001 -> 0x7FFF, V=1, N=0.
- MUL 0xFFFD*0x0007 (-3*7):
  - in_ready=0 and busy=1 for 16 cycles.
  - out_valid exactly 17 cycles after accept; out=0xFFEB, N=1, V=0.
  - MUL 0x0100*0x0100 -> 0x0000, Z=1, V=1.
- Backpressure:
  - ADD 1+2 with out_ready=0 for 5 cycles -> out=0x0003 stable, in_ready=0 throughout.
  - Then out_ready=1 with in_valid=1 (AND 0x0F0F&0x00FF) in the same cycle -> next cycle out=0x000F.
- Reset mid-op: assert reset_n=0 during MUL cycle 8 -> out, flags, out_valid, busy = 0 immediately. After release, in_ready=1, no stale result, and ADD 2+3 -> 0x0005.
- NOT B=0x00FF -> 0xFF00, N=1. LSL 0x4000 -> 0x8000, V=1. ASR 0x8001 -> 0xC000, N=1, V=0. MOV B=0x0000 -> Z=1. MUL_EN=0 build: MUL -> out=0, V=1, latency 1.
